// File: rtl/aes128_top.sv
// Iterative AES-128 encryption core. One cipher round per clock and on-the-fly
// key expansion. A load in IDLE performs the initial AddRoundKey. Ten RUN cycles
// then produce the ciphertext together with a one-cycle valid strobe.
module aes128_top (
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);

    typedef enum logic {IDLE, RUN} fsm_t;

    // The S-box is built as the GF(2^8) inverse followed by the FIPS-197
    // affine transform.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    // Computes x^254, which is x^-1 for nonzero x. The result is 0 for x = 0.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] acc;
        logic [7:0] sq;
        acc = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc ^ {acc[6:0], acc[7]} ^ {acc[5:0], acc[7:6]} ^
               {acc[4:0], acc[7:5]} ^ {acc[3:0], acc[7:4]} ^ 8'h63;
    endfunction

    // MixColumns on a single column. Byte 0 of the column is in the top bits.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    fsm_t         fsm, fsm_nxt;
    logic [3:0]   round;
    logic [127:0] state_q;
    logic [127:0] key_q;

    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [31:0]  rot_w;
    logic [31:0]  sub_w;
    logic [7:0]   rcon;
    logic [127:0] next_key;
    logic [127:0] round_out;
    logic [127:0] round_result;

    // Sixteen S-boxes on the state bytes. Byte n is at bits [127-8n -: 8].
    for (genvar n = 0; n < 16; n++) begin : g_state_sbox
        assign sb[n] = sbox(state_q[127-8*n -: 8]);
    end

    // Four S-boxes perform SubWord(RotWord(w3)) for the key schedule.
    assign rot_w = {key_q[23:0], key_q[31:24]};
    for (genvar j = 0; j < 4; j++) begin : g_key_sbox
        assign sub_w[31-8*j -: 8] = sbox(rot_w[31-8*j -: 8]);
    end

    // Round constant for the round key that is derived in this cycle.
    always_comb begin
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Next round key. Each word is the XOR of the previous word with the
    // same-position word of the old key.
    always_comb begin
        next_key[127:96] = key_q[127:96] ^ sub_w ^ {rcon, 24'h000000};
        next_key[95:64]  = key_q[95:64]  ^ next_key[127:96];
        next_key[63:32]  = key_q[63:32]  ^ next_key[95:64];
        next_key[31:0]   = key_q[31:0]   ^ next_key[63:32];
    end

    // ShiftRows and MixColumns. The final round omits MixColumns.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        sr        = '{default: 8'h00};
        round_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r+4*c] = sb[r+4*((c+r)%4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (round == 4'd10)
                round_out[127-32*c -: 32] = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
            else
                round_out[127-32*c -: 32] = mix_col({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
        end
    end

    assign round_result = round_out ^ next_key;

    // FSM state register.
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (AES_rst) fsm <= IDLE;
        else         fsm <= fsm_nxt;
    end

    // Next-state logic. A start is accepted only in IDLE, and round 10 ends RUN.
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE: if (AES_en) fsm_nxt = RUN;
            RUN:  if (round == 4'd10) fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    // Datapath: load with the whitening key, iterate the rounds, and publish
    // the result with a one-cycle strobe.
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            round              <= 4'd0;
            state_q            <= '0;
            key_q              <= '0;
            AES_data_out       <= '0;
            AES_data_out_valid <= 1'b0;
        end else begin
            AES_data_out_valid <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (AES_en) begin
                        state_q <= AES_data_in ^ AES_key_in;
                        key_q   <= AES_key_in;
                        round   <= 4'd1;
                    end
                end
                RUN: begin
                    state_q <= round_result;
                    key_q   <= next_key;
                    round   <= round + 4'd1;
                    if (round == 4'd10) begin
                        AES_data_out       <= round_result;
                        AES_data_out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_top.sv
// Self-checking bench for aes128_top. The reference model is a straightforward
// FIPS-197 encryption that builds its S-box table from log/antilog generation.
module tb_aes128_top;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [127:0] din;
    logic [127:0] kin;
    logic [127:0] dout;
    logic         dvalid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbox_tbl [256];

    aes128_top dut (
        .AES_clk            (clk),
        .AES_rst            (rst),
        .AES_en             (en),
        .AES_data_in        (din),
        .AES_key_in         (kin),
        .AES_data_out       (dout),
        .AES_data_out_valid (dvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Walk p over the powers of 3 and q over the powers of 1/3, so that q = p^-1.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ m_xt(p);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_tbl[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_tbl[0] = 8'h63;
    endtask

    // Reference model: expand the full 44-word key schedule, then run the
    // rounds on a byte array.
    function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rk;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]], sbox_tbl[t[31:24]]};
                t = t ^ {rc, 24'h0};
                rc = m_xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ key[127-8*n -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int n = 0; n < 16; n++) s[n] = sbox_tbl[s[n]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    u[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++) begin
                a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
                if (rnd != 10) begin
                    u[4*c]   = m_xt(a0) ^ (m_xt(a1) ^ a1) ^ a2 ^ a3;
                    u[4*c+1] = a0 ^ m_xt(a1) ^ (m_xt(a2) ^ a2) ^ a3;
                    u[4*c+2] = a0 ^ a1 ^ m_xt(a2) ^ (m_xt(a3) ^ a3);
                    u[4*c+3] = (m_xt(a0) ^ a0) ^ a1 ^ a2 ^ m_xt(a3);
                end
            end
            rk = {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
            for (int n = 0; n < 16; n++) s[n] = u[n] ^ rk[127-8*n -: 8];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Pulse AES_en for one cycle, optionally scramble the inputs while the
    // core runs, and check latency, data and the single-cycle strobe.
    task automatic run_one(input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] exp, input bit scramble);
        int cyc;
        bit found;
        @(negedge clk);
        kin = key;
        din = pt;
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        if (scramble) begin
            din = rand128();
            kin = rand128();
        end
        cyc   = 0;
        found = 0;
        while (!found && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (dvalid) found = 1;
            else if (scramble) begin
                din = rand128();
                kin = rand128();
            end
        end
        check("latency", 128'(cyc), 128'd10);
        check("ciphertext", dout, exp);
        @(negedge clk);
        check("valid_single", 128'(dvalid), 128'd0);
        check("out_hold", dout, exp);
    endtask

    initial begin
        logic [127:0] k, p, e;
        logic         exp_v;
        build_sbox();
        rst = 1'b1;
        en  = 1'b0;
        din = '0;
        kin = '0;
        repeat (3) @(negedge clk);
        check("reset_data", dout, 128'h0);
        check("reset_valid", 128'(dvalid), 128'd0);
        rst = 1'b0;

        // Known-answer vectors.
        run_one(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);
        run_one(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32, 1'b1);
        run_one(128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b0);

        // Random vectors against the model. Every other vector has its inputs
        // scrambled during RUN.
        for (int i = 0; i < 8; i++) begin
            k = rand128();
            p = rand128();
            run_one(k, p, model_encrypt(k, p), i[0]);
        end

        // With AES_en low, the core stays idle and the output holds while the
        // inputs wander.
        e = dout;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            din = rand128();
            kin = rand128();
            check("idle_valid", 128'(dvalid), 128'd0);
            check("idle_hold", dout, e);
        end

        // Hold AES_en high for 51 edges. Loads occur at 0,11,22,33,44, and the
        // strobe follows 10 edges after each load.
        k = rand128();
        p = rand128();
        e = model_encrypt(k, p);
        @(negedge clk);
        kin = k;
        din = p;
        en  = 1'b1;
        for (int i = 0; i < 81; i++) begin
            @(negedge clk);
            exp_v = (i >= 10) && ((i - 10) % 11 == 0) && (i - 10 <= 50);
            check("stream_valid", 128'(dvalid), 128'(exp_v));
            if (exp_v) check("stream_data", dout, e);
            if (i == 50) en = 1'b0;
        end

        // Reset during round 5 clears the outputs at once, and the aborted
        // operation never produces a strobe.
        k = rand128();
        p = rand128();
        @(negedge clk);
        kin = k;
        din = p;
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_data", dout, 128'h0);
        check("abort_valid", 128'(dvalid), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("abort_no_pulse", 128'(dvalid), 128'd0);
        end
        run_one(k, p, model_encrypt(k, p), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
